async_fifo_rd_ctrl: RTL

Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It synchronises the Gray-coded write pointer and derives empty/level from it. It drives the read port of the dual-port RAM and delivers words to the consumer over a valid/ready interface through a 2-entry output buffer. Its Gray-coded read pointer is exported to the write domain for full detection.

---
 rtl/async_fifo_rd_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_rd_ctrl
// Brief    : Read-side controller of an asynchronous FIFO (read clock domain).
//            Synchronises the Gray write pointer, computes empty/level, drives
//            the RAM read port and feeds a 2-entry valid/ready output buffer.
//            Optional macro ASYNC_FIFO_RD_SYNC3_EN selects a 3-flop
//            write-pointer synchroniser instead of the default 2 flops.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PTR_W = ADDR_WIDTH + 1;
`ifdef ASYNC_FIFO_RD_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    logic [PTR_W-1:0]      r_wr_sync [SYNC_STAGES];
    logic [PTR_W-1:0]      w_wr_bin_sync;
    logic [PTR_W-1:0]      r_rd_bin;
    logic [PTR_W-1:0]      w_rd_bin_nxt;
    logic                  r_in_flight;
    logic [1:0]            r_buf_cnt;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  w_pop;
    logic [2:0]            w_occ;

    // Multi-flop synchroniser for the write pointer coming from the write domain
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_wr_sync[i] <= '0;
            end
        end else begin
            r_wr_sync[0] <= wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wr_sync[i] <= r_wr_sync[i-1];
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_wr_bin_sync = '0;
        for (int i = 0; i < PTR_W; i++) begin
            w_wr_bin_sync[i] = ^(r_wr_sync[SYNC_STAGES-1] >> i);
        end
    end

    // Occupancy seen from the read side; the extra MSB distinguishes full from empty
    assign rd_level = w_wr_bin_sync - r_rd_bin;
    assign empty    = (rd_level == '0);

    // Issue a read only if the word in flight plus buffered words stay within two
    assign w_pop       = dout_valid & dout_ready;
    assign w_occ       = {1'b0, r_buf_cnt} + {2'b00, r_in_flight};
    assign mem_rd_en   = !empty && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign mem_rd_addr = r_rd_bin[ADDR_WIDTH-1:0];

    assign w_rd_bin_nxt = mem_rd_en ? (r_rd_bin + {{ADDR_WIDTH{1'b0}}, 1'b1}) : r_rd_bin;

    // Read pointer: binary counter plus registered Gray copy for the write domain
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_rd_bin    <= '0;
            rd_ptr_gray <= '0;
        end else begin
            r_rd_bin    <= w_rd_bin_nxt;
            rd_ptr_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
        end
    end

    // RAM data arrives one cycle after the read was issued
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= mem_rd_en;
        end
    end

    // Two-entry output buffer, r_buf0 is the head presented to the consumer
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_buf_cnt <= 2'd0;
        end else begin
            case ({r_in_flight, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_buf0    <= mem_rd_data;
                        r_buf_cnt <= 2'd1;
                    end else begin
                        r_buf1    <= mem_rd_data;
                        r_buf_cnt <= 2'd2;
                    end
                end
                2'b01: begin
                    r_buf0    <= r_buf1;
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the captured word enters; count unchanged
                    if (r_buf_cnt == 2'd1) begin
                        r_buf0 <= mem_rd_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= mem_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout_valid = (r_buf_cnt != 2'd0);
    assign dout_data  = r_buf0;

endmodule
`default_nettype wire
